da_serial_mac: RTL and testbench

- Bit-serial distributed-arithmetic MAC engine for the 8-tap DA FIR slice. It wraps the coefficient partial-sum LUT, driving the LUT from one side and consuming its output on the other.
- Holds an 8-deep input-sample delay line and scans one bit-plane per cycle, LSB first. Each cycle it drives the 8-bit LUT address (one bit per tap) and shift-accumulates the returned 32-bit partial sum.
- Outputs one filtered sample per accepted input through a valid/ready handshake.

---
 rtl/da_serial_mac_if.sv | 37 +++
 rtl/da_serial_mac.sv | 132 +++++++++++++
 tb/tb_da_serial_mac.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/da_serial_mac_if.sv
// rtl/da_serial_mac_if.sv - sample, LUT and result signals of the DA serial MAC (flush port with DA_FLUSH_EN)
interface da_serial_mac_if #(
   parameter int DATA_W = 16,
   parameter int TAPS   = 8,
   parameter int LUT_W  = 32,
   parameter int OUT_W  = 48
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [TAPS-1:0]   lut_addr;
   logic [LUT_W-1:0]  lut_data;
   logic              out_valid;
   logic [OUT_W-1:0]  out_data;
   logic              busy;
`ifdef DA_FLUSH_EN
   logic              flush;
`endif

   // engine side
   modport master (
      input  in_valid, in_data, lut_data,
`ifdef DA_FLUSH_EN
      input  flush,
`endif
      output in_ready, lut_addr, out_valid, out_data, busy
   );

   // sample source, LUT and result sink side
   modport slave (
      output in_valid, in_data, lut_data,
`ifdef DA_FLUSH_EN
      output flush,
`endif
      input  in_ready, lut_addr, out_valid, out_data, busy
   );
endinterface

// File: rtl/da_serial_mac.sv
// rtl/da_serial_mac.sv - bit-serial distributed-arithmetic FIR MAC engine (optional flush: DA_FLUSH_EN)
module da_serial_mac #(
   parameter int DATA_W = 16,
   parameter int TAPS   = 8,
   parameter int LUT_W  = 32,
   parameter int OUT_W  = 48
) (
   input  logic           clk,
   input  logic           rst_n,
   da_serial_mac_if.master bus
);
   localparam int              CNT_W    = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] x_q [TAPS];
   logic [DATA_W-1:0] x_d [TAPS];
   logic [OUT_W-1:0]  acc_q, acc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [OUT_W-1:0]  out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;
   logic [OUT_W-1:0]  lut_ext;
   logic [OUT_W-1:0]  term;
   logic              flush_w;

`ifdef DA_FLUSH_EN
   assign flush_w = bus.flush;
`else
   assign flush_w = 1'b0;
`endif

   // partial sum weighted by the current bit-plane
   assign lut_ext = {{(OUT_W - LUT_W){bus.lut_data[LUT_W-1]}}, bus.lut_data};
   assign term    = lut_ext << cnt_q;

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;

   // LUT address: one bit per tap from the bit-plane being scanned, zero outside CALC
   always_comb begin
      bus.lut_addr = '0;
      if (state_q == S_CALC) begin
         for (int i = 0; i < TAPS; i++) begin
            bus.lut_addr[i] = x_q[i][cnt_q];
         end
      end
   end

   // next-state: accept and shift, serial shift-accumulate, publish result
   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      out_data_d  = out_data_q;
      out_valid_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               x_d[0] = bus.in_data;
               for (int i = 1; i < TAPS; i++) begin
                  x_d[i] = x_q[i-1];
               end
               acc_d   = '0;
               cnt_d   = '0;
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            if (cnt_q == CNT_LAST) begin
               // sign bit-plane carries negative weight in two's complement
               acc_d   = acc_q - term;
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               acc_d = acc_q + term;
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            out_data_d  = acc_q;
            out_valid_d = 1'b1;
            state_d     = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // flush wins over any same-cycle acceptance or completion
      if (flush_w) begin
         for (int i = 0; i < TAPS; i++) begin
            x_d[i] = '0;
         end
         acc_d       = '0;
         cnt_d       = '0;
         out_data_d  = out_data_q;
         out_valid_d = 1'b0;
         state_d     = S_IDLE;
      end
   end

   // state register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         for (int i = 0; i < TAPS; i++) begin
            x_q[i] <= '0;
         end
         acc_q       <= '0;
         cnt_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end
endmodule

// File: tb/tb_da_serial_mac.sv
// tb/tb_da_serial_mac.sv - self-checking bench for da_serial_mac with a behavioural FIR model (DA_FLUSH_EN aware)
module tb_da_serial_mac;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   da_serial_mac_if bus ();

   da_serial_mac dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int b_tab [8] = '{1, 1, -5, -12, 22, 39, -62, -94};

   // coefficient partial-sum LUT: sum of b_i over the address bits that are set
   always_comb begin
      int lut_sum;
      lut_sum = 0;
      for (int i = 0; i < 8; i++) begin
         if (bus.lut_addr[i]) lut_sum = lut_sum + b_tab[i];
      end
      bus.lut_data = lut_sum;
   end

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int n_acc = 0;
   longint got[$];

   task automatic chk(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- behavioural model ----------------
   typedef struct {
      int     due;
      longint val;
   } pend_t;

   pend_t       pend[$];
   logic [15:0] hist [8];
   bit          model_on = 0;
   bit          idle = 1;
   int          a_edge = -1000;
   longint      last_out = 0;
   logic        flush_s;

`ifdef DA_FLUSH_EN
   assign flush_s = bus.flush;
`else
   assign flush_s = 1'b0;
`endif

   function automatic longint fir_out();
      longint s = 0;
      for (int i = 0; i < 8; i++) s += longint'(b_tab[i]) * longint'($signed(hist[i]));
      return s;
   endfunction

   // compare DUT against the model every cycle, then advance the model to the next edge
   always @(negedge clk) begin
      bit        exp_valid;
      bit        exp_ready;
      bit        calc;
      logic [7:0] exp_addr;
      int        cnt;
      exp_ready = 1;
      if (model_on) begin
         exp_valid = 0;
         if (pend.size() > 0 && pend[0].due == cyc) begin
            exp_valid = 1;
            last_out  = pend[0].val;
            void'(pend.pop_front());
         end
         exp_ready = idle || (cyc >= a_edge + 17);
         calc      = !idle && (cyc >= a_edge) && (cyc <= a_edge + 15);
         exp_addr  = '0;
         if (calc) begin
            cnt = cyc - a_edge;
            for (int i = 0; i < 8; i++) exp_addr[i] = hist[i][cnt];
         end
         chk("in_ready", longint'(bus.in_ready), longint'(exp_ready));
         chk("busy", longint'(bus.busy), longint'(!exp_ready));
         chk("lut_addr", longint'(bus.lut_addr), longint'(exp_addr));
         chk("out_valid", longint'(bus.out_valid), longint'(exp_valid));
         chk("out_data", longint'($signed(bus.out_data)), last_out);
      end
      if (bus.out_valid === 1'b1) got.push_back(longint'($signed(bus.out_data)));
      if (!rst_n) begin
         model_on = 1;
         idle     = 1;
         a_edge   = -1000;
         last_out = 0;
         pend.delete();
         for (int i = 0; i < 8; i++) hist[i] = '0;
      end else if (model_on && flush_s === 1'b1) begin
         idle = 1;
         pend.delete();
         for (int i = 0; i < 8; i++) hist[i] = '0;
      end else if (model_on && exp_ready && bus.in_valid === 1'b1) begin
         for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = bus.in_data;
         a_edge  = cyc + 1;
         idle    = 0;
         pend.push_back('{due: a_edge + 17, val: fir_out()});
         n_acc++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic send(input logic [15:0] v);
      int c0;
      c0 = n_acc;
      bus.in_valid = 1'b1;
      bus.in_data  = v;
      for (int k = 0; k < 60; k++) begin
         @(posedge clk); #1;
         if (n_acc != c0) break;
      end
      chk("accept_timeout", longint'(n_acc != c0), 1);
      bus.in_valid = 1'b0;
      bus.in_data  = 16'($urandom);
   endtask

   task automatic wait_outs(input int n);
      for (int k = 0; k < 60 * n; k++) begin
         if (got.size() >= n) break;
         @(posedge clk); #1;
      end
      chk("output_timeout", longint'(got.size() >= n), 1);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      got.delete();
   endtask

   longint imp_exp [9]  = '{1, 1, -5, -12, 22, 39, -62, -94, 0};
   longint step_exp [8] = '{1, 2, -3, -15, 7, 46, -16, -110};

   initial begin
      int c0;
      int v;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
`ifdef DA_FLUSH_EN
      bus.flush = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk); #1;
      chk("rst_out_valid", longint'(bus.out_valid), 0);
      chk("rst_out_data", longint'(bus.out_data), 0);
      chk("rst_in_ready", longint'(bus.in_ready), 1);
      chk("rst_lut_addr", longint'(bus.lut_addr), 0);
      chk("rst_busy", longint'(bus.busy), 0);

      // impulse response
      do_reset();
      send(16'd1);
      repeat (8) send(16'd0);
      wait_outs(9);
      for (int k = 0; k < 9; k++) if (k < got.size()) chk($sformatf("impulse_%0d", k), got[k], imp_exp[k]);

      // sign handling
      do_reset(); send(16'hFFFF); wait_outs(1);
      if (got.size() > 0) chk("sign_ffff", got[0], -1);
      do_reset(); send(16'h8000); wait_outs(1);
      if (got.size() > 0) chk("sign_8000", got[0], -32768);
      do_reset(); send(16'h7FFF); wait_outs(1);
      if (got.size() > 0) chk("sign_7fff", got[0], 32767);

      // step response
      do_reset();
      repeat (8) send(16'd1);
      wait_outs(8);
      for (int k = 0; k < 8; k++) if (k < got.size()) chk($sformatf("step_%0d", k), got[k], step_exp[k]);

`ifdef DA_FLUSH_EN
      // flush clears the delay line after the step sequence
      @(posedge clk); #1;
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      got.delete();
      send(16'd1);
      wait_outs(1);
      if (got.size() > 0) chk("flush_then_1", got[0], 1);
`endif

      // handshake: in_valid held with data changing every cycle
      do_reset();
      c0 = n_acc;
      v  = 100;
      bus.in_valid = 1'b1;
      repeat (72) begin
         bus.in_data = 16'(v);
         v++;
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      chk("hs_accepts", longint'(n_acc - c0), 4);
      wait_outs(4);
      if (got.size() > 3) chk("hs_out3", got[3], -1500);

      // reset while cnt=7
      do_reset();
      send(16'd3);
      send(16'd5);
      repeat (7) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      wait_outs(1);
      got.delete();
      repeat (30) @(posedge clk);
      #1;
      chk("midcalc_no_out", longint'(got.size()), 0);
      send(16'd1);
      wait_outs(1);
      if (got.size() > 0) chk("midcalc_then_1", got[0], 1);

      // randomized samples with noise on in_valid/in_data while busy
      do_reset();
      for (int it = 0; it < 40; it++) begin
         send(16'($urandom));
         repeat ($urandom_range(0, 12)) begin
            bus.in_valid = 1'($urandom);
            bus.in_data  = 16'($urandom);
            @(posedge clk); #1;
         end
         bus.in_valid = 1'b0;
      end
      repeat (40) @(posedge clk);
      #1;

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
      $fatal(1);
   end
endmodule
